imem_loader: RTL and testbench

Program loader that writes the instruction memory from a byte stream (UART receiver or testbench), replacing the `$readmemh` preload for hardware runs. It accepts a word count followed by little-endian instruction bytes, assembles 32-bit words, and drives the write port of a writable instruction memory. While it loads, it holds the pipeline stalled.

---
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Loads instruction memory from a byte stream (count byte, then
//               little-endian words) and stalls the pipeline while loading.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        loading,
  output logic        done,
  output logic        error
);

  localparam int IDXW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_n;
  logic [IDXW-1:0]   r_idx;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_asm;
  logic [31:0]       r_wa;
  logic [31:0]       r_wd;
  logic              w_xfer;
  logic              w_more;
  logic              w_too_big;
  logic              w_restart;

  assign w_xfer    = rx_valid && rx_ready;
  assign w_more    = ({{(32-IDXW){1'b0}}, r_idx} + 32'd1) < {24'd0, r_n};
  assign w_too_big = {24'd0, rx_data} > 32'(DEPTH);
  assign w_restart = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) w_next = S_COUNT;
      end
      S_COUNT: begin
        if (w_xfer) begin
          if (rx_data == 8'd0)  w_next = S_DONE;
          else if (w_too_big)   w_next = S_ERROR;
          else                  w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_xfer && r_bcnt == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = w_more ? S_DATA : S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Completed words are latched separately so wa/wd stay stable between writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n    <= 8'd0;
      r_idx  <= '0;
      r_bcnt <= 2'd0;
      r_asm  <= 24'd0;
      r_wa   <= 32'd0;
      r_wd   <= 32'd0;
    end else begin
      if (w_restart) begin
        r_idx  <= '0;
        r_bcnt <= 2'd0;
      end
      if (r_state == S_COUNT && w_xfer) begin
        r_n <= rx_data;
      end
      if (r_state == S_DATA && w_xfer) begin
        if (r_bcnt == 2'd3) begin
          r_wd   <= {rx_data, r_asm};
          r_wa   <= {{(30-IDXW){1'b0}}, r_idx, 2'b00};
          r_bcnt <= 2'd0;
        end else begin
          r_asm[8*r_bcnt +: 8] <= rx_data;
          r_bcnt               <= r_bcnt + 2'd1;
        end
      end
      if (r_state == S_WRITE) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign rx_ready = (r_state == S_COUNT) || (r_state == S_DATA);
  assign we       = (r_state == S_WRITE);
  assign loading  = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_WRITE);
  assign done     = (r_state == S_DONE);
  assign error    = (r_state == S_ERROR);
  assign wa       = r_wa;
  assign wd       = r_wd;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader; expected writes are queued by
//               the stimulus and checked by an independent write monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        loading;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;
  int n_we  = 0;
  int n_exp = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words[64];

  imem_loader #(.DEPTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .loading  (loading),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every we pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (we) begin
      n_we++;
      if (exp_q.size() == 0) begin
        chk("unexpected_we_wa", wa, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_wa", wa, e[63:32]);
        chk("write_wd", wd, e[31:0]);
      end
      chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_loading", {31'd0, loading}, 32'd1);
    chk("start_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("start_done_clr", {30'd0, done, error}, 32'd0);
  endtask

  // Returns just after the edge that accepted the byte
  task automatic send(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      rx_valid = 1'b0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("rx_ready_timeout", 32'd0, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic load(input int n, input bit gaps);
    logic [31:0] w;
    send(8'(n), gaps);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      exp_q.push_back({32'(i * 4), w});
      n_exp++;
      for (int k = 0; k < 4; k++) send(w[8*k +: 8], gaps);
      chk("we_after_4th", {31'd0, we}, 32'd1);
    end
    tick();
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_loading", {31'd0, loading}, 32'd0);
    chk("end_error", {31'd0, error}, 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {26'd0, rx_ready, we, loading, done, error, 1'b0}, 32'd0);
    chk({tag, "_wa"}, wa, 32'd0);
    chk({tag, "_wd"}, wd, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    words[0] = 32'h00A0_0013;
    words[1] = 32'h00A0_0293;

    // Reset with rx_valid high for two cycles
    tick();
    chk_reset_outs("reset1");
    tick();
    chk_reset_outs("reset2");
    reset    = 1'b0;
    rx_valid = 1'b0;
    tick();

    // Basic back-to-back load
    pulse_start();
    load(2, 1'b0);

    // Restart from DONE, with gaps and spurious start pulses
    pulse_start();
    load(2, 1'b1);

    // N = 0
    pulse_start();
    send(8'd0, 1'b0);
    chk("n0_done", {30'd0, done, error}, 32'd2);

    // N = 65 exceeds DEPTH
    pulse_start();
    send(8'd65, 1'b0);
    chk("n65_error", {30'd0, done, error}, 32'd1);
    chk("n65_loading", {31'd0, loading}, 32'd0);

    // N = 64 full memory, last address 0xFC
    for (int i = 0; i < 64; i++) words[i] = {8'(i), 8'hC3, 8'(255 - i), 8'h5A};
    pulse_start();
    load(64, 1'b0);

    // Reset during word 1 of an N=3 load
    words[0] = 32'hDEAD_BEEF;
    words[1] = 32'h1234_5678;
    pulse_start();
    send(8'd3, 1'b0);
    exp_q.push_back({32'd0, words[0]});
    n_exp++;
    for (int k = 0; k < 4; k++) send(words[0][8*k +: 8], 1'b0);
    send(8'h78, 1'b0);
    send(8'h56, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outs("midreset");
    tick();
    chk_reset_outs("midreset_idle");

    // Fresh load after reset starts at address 0
    words[0] = 32'hCAFE_F00D;
    pulse_start();
    load(1, 1'b0);

    repeat (3) tick();
    chk("we_count", 32'(n_we), 32'(n_exp));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
